// File: rtl/ro_puf_pkg.sv
// Shared RO PUF definitions: measurement FSM states and default sizes used
// by the counter pair, the A/B comparator and the challenge sequencer.
package ro_puf_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      MEASURE,
      DONE
   } ro_state_e;

   localparam int CNT_W_DEF  = 16;
   localparam int WINDOW_DEF = 50000;

endpackage

// File: rtl/ro_edge_counter.sv
// One RO channel: synchronizer, rising-edge detect and sticky saturating
// edge counter.
module ro_edge_counter #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ro,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] count,
   output logic             sat
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   sat_q;
   logic                   rise;

   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

   // count/sat include this cycle's edge so the final window cycle is seen
   // by whoever captures them on the closing clock edge.
   assign count = (en && rise && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
   assign sat   = sat_q | (count == CNT_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         cnt_q  <= '0;
         sat_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], ro};
         prev_q <= sync_q[SYNC_STAGES-1];
         if (clr) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
         end else begin
            cnt_q <= count;
            sat_q <= sat;
         end
      end
   end

endmodule

// File: rtl/ro_count_pair.sv
// RO PUF measurement front end: counts rising edges of two ring oscillators
// over a fixed clk window and presents both counts with a done pulse.
module ro_count_pair
   import ro_puf_pkg::*;
#(
   parameter int WINDOW_CYCLES = WINDOW_DEF,
   parameter int CNT_W         = CNT_W_DEF,
   parameter int SYNC_STAGES   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             ro_a,
   input  logic             ro_b,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] count_a,
   output logic [CNT_W-1:0] count_b,
   output logic             sat_a,
   output logic             sat_b
);

   localparam int WIN_W = $clog2(WINDOW_CYCLES + 1);
   localparam int SET_W = $clog2(SYNC_STAGES + 1);

   ro_state_e        state_q;
   logic [WIN_W-1:0] win_q;
   logic [SET_W-1:0] set_q;
   logic             cnt_clr;
   logic             cnt_en;
   logic [CNT_W-1:0] wcnt_a, wcnt_b;
   logic             wsat_a, wsat_b;

   assign cnt_clr = (state_q == IDLE) && start;
   assign cnt_en  = (state_q == MEASURE);

   ro_edge_counter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_cnt_a (
      .clk(clk), .rst(rst), .ro(ro_a), .clr(cnt_clr), .en(cnt_en),
      .count(wcnt_a), .sat(wsat_a)
   );

   ro_edge_counter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_cnt_b (
      .clk(clk), .rst(rst), .ro(ro_b), .clr(cnt_clr), .en(cnt_en),
      .count(wcnt_b), .sat(wsat_b)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         win_q   <= '0;
         set_q   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         count_a <= '0;
         count_b <= '0;
         sat_a   <= 1'b0;
         sat_b   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= SETTLE;
                  busy    <= 1'b1;
                  set_q   <= SET_W'(SYNC_STAGES);
               end
            end
            SETTLE: begin
               if (set_q == SET_W'(1)) begin
                  state_q <= MEASURE;
                  win_q   <= WIN_W'(WINDOW_CYCLES);
               end else begin
                  set_q <= set_q - 1'b1;
               end
            end
            MEASURE: begin
               // Last window cycle: results land together with the done pulse.
               if (win_q == WIN_W'(1)) begin
                  state_q <= DONE;
                  done    <= 1'b1;
                  count_a <= wcnt_a;
                  count_b <= wcnt_b;
                  sat_a   <= wsat_a;
                  sat_b   <= wsat_b;
               end else begin
                  win_q <= win_q - 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done    <= 1'b0;
               busy    <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ro_count_pair.sv
// Directed bench for ro_count_pair: counts, static inputs, saturation,
// start-while-busy, mid-measure reset and back-to-back runs.
module tb_ro_count_pair;

   localparam int WIN = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        ro_a = 1'b0;
   logic        ro_b = 1'b0;
   logic        busy, done, sat_a, sat_b;
   logic [15:0] count_a, count_b;
   logic        busy4, done4, sat_a4, sat_b4;
   logic [3:0]  count_a4, count_b4;

   int per_a = 10, per_b = 4;
   logic lvl_a = 1'b0, lvl_b = 1'b0;
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   ro_count_pair #(.WINDOW_CYCLES(WIN), .CNT_W(16), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .start(start), .ro_a(ro_a), .ro_b(ro_b),
      .busy(busy), .done(done), .count_a(count_a), .count_b(count_b),
      .sat_a(sat_a), .sat_b(sat_b)
   );

   ro_count_pair #(.WINDOW_CYCLES(WIN), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
      .clk(clk), .rst(rst), .start(start), .ro_a(ro_a), .ro_b(ro_b),
      .busy(busy4), .done(done4), .count_a(count_a4), .count_b(count_b4),
      .sat_a(sat_a4), .sat_b(sat_b4)
   );

   // Square-wave ring-oscillator models; period 0 means hold the static level.
   initial begin
      int ta, tb;
      ta = 0;
      tb = 0;
      forever begin
         @(negedge clk);
         ta = (per_a == 0 || ta + 1 >= per_a) ? 0 : ta + 1;
         tb = (per_b == 0 || tb + 1 >= per_b) ? 0 : tb + 1;
         ro_a = (per_a == 0) ? lvl_a : (ta < per_a / 2);
         ro_b = (per_b == 0) ? lvl_b : (tb < per_b / 2);
      end
   end

   // One start pulse, then sample 250 cycles; i=1 is the cycle after the start edge.
   task automatic run_meas(input bit extra, output int lat, output int bcnt,
                           output int dcnt);
      lat  = -1;
      bcnt = 0;
      dcnt = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 1; i <= 250; i++) begin
         if (busy) bcnt++;
         if (done) begin
            dcnt++;
            if (lat < 0) lat = i;
         end
         start = (extra && (i == 30 || i == 60)) ? 1'b1 : 1'b0;
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, count_a, count_b, sat_a, sat_b} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=0",
                  {busy, done, count_a, count_b, sat_a, sat_b});
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin
         failures++;
         $display("FAIL reset_release got busy/done=%b exp=00", {busy, done});
      end
   endtask

   task automatic test_basic();
      int lat, bcnt, dcnt;
      per_a = 10;
      per_b = 4;
      repeat (5) @(negedge clk);
      run_meas(1'b0, lat, bcnt, dcnt);
      checks++;
      if (lat !== 103) begin failures++; $display("FAIL basic_latency got=%0d exp=103", lat); end
      checks++;
      if (dcnt !== 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", dcnt); end
      checks++;
      if (bcnt !== 103) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=103", bcnt); end
      checks++;
      if (count_a !== 16'd10) begin failures++; $display("FAIL basic_count_a got=%0d exp=10", count_a); end
      checks++;
      if (count_b !== 16'd25) begin failures++; $display("FAIL basic_count_b got=%0d exp=25", count_b); end
      checks++;
      if ({sat_a, sat_b} !== 2'b00) begin failures++; $display("FAIL basic_sat got=%b exp=00", {sat_a, sat_b}); end
   endtask

   task automatic test_static();
      int lat, bcnt, dcnt;
      per_a = 0;
      per_b = 0;
      lvl_a = 1'b0;
      lvl_b = 1'b1;
      repeat (5) @(negedge clk);
      run_meas(1'b0, lat, bcnt, dcnt);
      checks++;
      if (dcnt !== 1) begin failures++; $display("FAIL static_done_count got=%0d exp=1", dcnt); end
      checks++;
      if (count_a !== 16'd0) begin failures++; $display("FAIL static_count_a got=%0d exp=0", count_a); end
      checks++;
      if (count_b !== 16'd0) begin failures++; $display("FAIL static_count_b got=%0d exp=0", count_b); end
   endtask

   task automatic test_saturation();
      int lat, bcnt, dcnt;
      per_a = 4;
      per_b = 20;
      repeat (5) @(negedge clk);
      run_meas(1'b0, lat, bcnt, dcnt);
      checks++;
      if (count_a4 !== 4'd15) begin failures++; $display("FAIL sat_count_a got=%0d exp=15", count_a4); end
      checks++;
      if (sat_a4 !== 1'b1) begin failures++; $display("FAIL sat_flag_a got=%b exp=1", sat_a4); end
      checks++;
      if (count_b4 !== 4'd5) begin failures++; $display("FAIL sat_count_b got=%0d exp=5", count_b4); end
      checks++;
      if (sat_b4 !== 1'b0) begin failures++; $display("FAIL sat_flag_b got=%b exp=0", sat_b4); end
      checks++;
      if (count_a !== 16'd25 || sat_a !== 1'b0) begin
         failures++;
         $display("FAIL wide_count_a got=%0d/%b exp=25/0", count_a, sat_a);
      end
   endtask

   task automatic test_start_busy();
      int lat, bcnt, dcnt;
      per_a = 10;
      per_b = 4;
      repeat (5) @(negedge clk);
      run_meas(1'b1, lat, bcnt, dcnt);
      checks++;
      if (dcnt !== 1) begin failures++; $display("FAIL busy_start_done_count got=%0d exp=1", dcnt); end
      checks++;
      if (lat !== 103) begin failures++; $display("FAIL busy_start_latency got=%0d exp=103", lat); end
      checks++;
      if (count_a !== 16'd10 || count_b !== 16'd25) begin
         failures++;
         $display("FAIL busy_start_counts got=%0d/%0d exp=10/25", count_a, count_b);
      end
   endtask

   task automatic test_reset_mid();
      int lat, bcnt, dcnt, nd;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (52) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, count_a, count_b, sat_a, sat_b} !== '0) begin
         failures++;
         $display("FAIL midreset_outputs got=%h exp=0",
                  {busy, done, count_a, count_b, sat_a, sat_b});
      end
      @(negedge clk);
      rst = 1'b0;
      nd = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (done || busy) nd++;
      end
      checks++;
      if (nd !== 0) begin failures++; $display("FAIL midreset_no_done got=%0d exp=0", nd); end
      run_meas(1'b0, lat, bcnt, dcnt);
      checks++;
      if (dcnt !== 1 || count_a !== 16'd10 || count_b !== 16'd25) begin
         failures++;
         $display("FAIL midreset_rerun got=%0d/%0d/%0d exp=1/10/25", dcnt, count_a, count_b);
      end
   endtask

   task automatic test_back_to_back();
      int d1, d2, bad;
      d1 = -1;
      d2 = -1;
      bad = 0;
      @(negedge clk);
      start = 1'b1;
      for (int i = 1; i <= 320; i++) begin
         @(negedge clk);
         if (done) begin
            if (count_a !== 16'd10 || count_b !== 16'd25) bad++;
            if (d1 < 0) d1 = i;
            else if (d2 < 0) d2 = i;
         end
      end
      start = 1'b0;
      checks++;
      if (d1 !== 103) begin failures++; $display("FAIL b2b_first_done got=%0d exp=103", d1); end
      checks++;
      if (d2 - d1 !== 104) begin failures++; $display("FAIL b2b_spacing got=%0d exp=104", d2 - d1); end
      checks++;
      if (bad !== 0) begin failures++; $display("FAIL b2b_counts got=%0d bad runs exp=0", bad); end
      repeat (120) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_static();
      test_saturation();
      test_start_busy();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ro_count_pair.md
# ro_count_pair

Measurement front end of the RO PUF. It counts rising edges of two ring-oscillator outputs over an identical fixed window of system clocks, then presents the two 16-bit counts. The counts feed the PUF's A/B magnitude comparator directly. A start/busy/done handshake lets the challenge sequencer request one measurement at a time.

## Interface
- `WINDOW_CYCLES`, default 50000: measurement window length in `clk` cycles; must be at least 1.
- `CNT_W`, default 16: width of each edge count. It matches the comparator's A/B width.
- `SYNC_STAGES`, default 2: number of synchronizer flops on each RO input; must be at least 2.
- `clk`, input, 1: system clock. This is the block's only clock.
- `rst`, input, 1: reset. Asynchronous, active-high.
- `start`, input, 1: measurement request. Sampled only in IDLE.
- `ro_a`, input, 1: ring oscillator A output. Asynchronous to `clk`.
- `ro_b`, input, 1: ring oscillator B output. Asynchronous to `clk`.
- `busy`, output, 1: high from SETTLE through DONE inclusive.
- `done`, output, 1: one-cycle pulse. The counts are valid from this cycle on.
- `count_a`, output, CNT_W: result count for A. Held until the next measurement's DONE.
- `count_b`, output, CNT_W: result count for B. Same behaviour as `count_a`.
- `sat_a`, output, 1: count A saturated during the last measurement.
- `sat_b`, output, 1: count B saturated during the last measurement.

## Operation
- FSM states: IDLE, SETTLE, MEASURE, DONE.
  - IDLE → SETTLE when `start`=1.
  - SETTLE lasts SYNC_STAGES cycles, then → MEASURE.
  - MEASURE lasts exactly WINDOW_CYCLES cycles, then → DONE.
  - DONE lasts 1 cycle, then → IDLE.
- Each RO input passes through a SYNC_STAGES flop synchronizer, followed by a previous-value register. A rising edge is the condition synced=1 and prev=0.
- SETTLE: the synchronizers and prev registers run, but no edges are counted. This flushes stale samples. The working counters clear to 0 on entry to SETTLE.
- MEASURE: each detected edge increments its working counter by 1, so at most one edge is counted per `clk`.
- Counters saturate at 2^CNT_W−1 and never wrap. Reaching the maximum sets that channel's sticky saturation flag for the current measurement.
- DONE: the working counts and flags are copied into `count_a`, `count_b`, `sat_a` and `sat_b`, and `done` is asserted.
- `start` while `busy`=1 is ignored and is not queued.
- `start` held high continuously starts back-to-back measurements: DONE → IDLE → SETTLE.
- Accuracy requires the RO frequency to be at most f_clk/4. Faster inputs alias; this is not detected.
- `rst` at any time clears everything immediately:
  - FSM → IDLE;
  - all counters, synchronizers, outputs and flags → 0.
  - A measurement in progress is discarded and `done` is not pulsed.

## Timing
- Reset values: `busy`=0, `done`=0, `count_a`=0, `count_b`=0, `sat_a`=0, `sat_b`=0.
- `start` is sampled high in IDLE at edge k. Then:
  - `busy`=1 from k+1;
  - MEASURE spans edges k+1+SYNC_STAGES through k+SYNC_STAGES+WINDOW_CYCLES;
  - `done`=1 and the new counts are visible in cycle k+1+SYNC_STAGES+WINDOW_CYCLES;
  - `busy`=0 from the following cycle.
- Total latency from start to done is SYNC_STAGES+WINDOW_CYCLES+1 cycles.
- All outputs are registered, with no combinational path from any input.
- The window counter is $clog2(WINDOW_CYCLES+1) bits wide. It loads at MEASURE entry and terminates on its final count, with no off-by-one: exactly WINDOW_CYCLES counting cycles.

## Structure
- Shared package `ro_puf_pkg` holds:
  - the state enum (IDLE, SETTLE, MEASURE, DONE);
  - `CNT_W_DEF`=16 and `WINDOW_DEF`=50000;
  - these are shared with the comparator and challenge sequencer.
- Sub-module `ro_edge_counter`, instantiated once per channel, contains the synchronizer, edge detect and saturating counter. Its controls are `clr` and `en`, and its outputs are `count` and `sat`.
- The top level holds the FSM, the window counter and the output registers.

## Test plan
- Bench parameters: WINDOW_CYCLES=100, SYNC_STAGES=2, unless stated otherwise.
- Basic counts: `ro_a` square wave with 10-clk period, `ro_b` with 4-clk period, one `start` pulse → exactly one `done`, 103 cycles after the start edge; `count_a`=10, `count_b`=25, `sat_a`=0, `sat_b`=0; `busy` high for 103 cycles.
- Static inputs: `ro_a`=0 and `ro_b`=1 held constant → `count_a`=0, `count_b`=0 at `done`.
- Saturation: CNT_W=4, `ro_a` period 4 → `count_a`=15, `sat_a`=1. `ro_b` period 20 → `count_b`=5, `sat_b`=0.
- Start during busy: extra `start` pulses at cycles 30 and 60 of a measurement → only one `done`; counts unchanged from the single-run values.
- Reset mid-measure: assert `rst` 50 cycles into MEASURE → all outputs 0 in the same cycle and no `done`. A subsequent `start` → normal counts 10/25.
- Back-to-back: `start` held high, periods 10/4 → `done` pulses 104 cycles apart, each run reporting 10/25.
